// File: rtl/retire_pair_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : retire_sync_pkg
// Purpose : Shared types and width helpers for the retire pair buffer.
//           Provides the default retirement record type and the width
//           functions used to size FIFO pointers, occupancy counters and
//           the signed skew output.
// Revision: 1.0 - initial release
// ============================================================================
package retire_sync_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4;

    // One retirement record (retired PC / instruction word).
    typedef logic [DEF_DATA_W-1:0] retire_rec_t;

    // Pointer width; a DEPTH of 1 would otherwise give a zero-width pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter must hold 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Signed difference of two counts in -DEPTH..+DEPTH needs one more bit.
    function automatic int skew_width(input int depth);
        return $clog2(depth) + 2;
    endfunction

    localparam int SKEW_W = skew_width(DEF_DEPTH);

endpackage : retire_sync_pkg
`default_nettype wire

// File: rtl/retire_pair_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module  : retire_fifo
// Purpose : Synchronous single-clock FIFO holding retirement records of one
//           core. Head is the oldest record (combinational read).
// Ports   : clk, rst      - clock, synchronous active-high reset
//           push, wr_data - write request / record (ignored while full)
//           pop           - remove head (ignored while empty)
//           head          - oldest record
//           full, empty   - occupancy flags decoded from registered count
//           count         - occupancy 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
module retire_fifo
    import retire_sync_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             head,
    output logic                          full,
    output logic                          empty,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through a valid count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule : retire_fifo
`default_nettype wire

// File: rtl/retire_pair_buffer.sv
`default_nettype none
// ============================================================================
// Module  : retire_pair_buffer
// Purpose : Decouples two free-running cores. Each core pushes retirement
//           records into its own FIFO; whenever both FIFOs hold a record,
//           one record from each is popped and emitted as a registered pair.
//           A core is stalled only while its own FIFO is full.
// Ports   : clk_i, rst_i           - clock, synchronous active-high reset
//           retire_N_i, data_N_i   - core N retirement strobe / record
//           stall_N_o              - core N must hold (its FIFO is full)
//           retire_o               - one-cycle pulse per emitted pair
//           data_1_o, data_2_o     - records of the pair (held otherwise)
//           skew_o                 - signed occupancy core1 - core2
//           mismatch_o             - sticky: unequal pair emitted
// Config  : RETIRE_PAIR_CMP_EN - when defined, enables the pair comparator
//           driving mismatch_o; otherwise mismatch_o is constant 0.
// Revision: 1.0 - initial release
// ============================================================================
module retire_pair_buffer
    import retire_sync_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          retire_1_i,
    input  logic [DATA_W-1:0]             data_1_i,
    input  logic                          retire_2_i,
    input  logic [DATA_W-1:0]             data_2_i,
    output logic                          stall_1_o,
    output logic                          stall_2_o,
    output logic                          retire_o,
    output logic [DATA_W-1:0]             data_1_o,
    output logic [DATA_W-1:0]             data_2_o,
    output logic [skew_width(DEPTH)-1:0]  skew_o,
    output logic                          mismatch_o
);

    localparam int CNT_W  = cnt_width(DEPTH);
    localparam int SKEW_W = skew_width(DEPTH);

    logic              w_push_1, w_push_2, w_pop;
    logic              w_full_1, w_full_2, w_empty_1, w_empty_2;
    logic [DATA_W-1:0] w_head_1, w_head_2;
    logic [CNT_W-1:0]  w_count_1, w_count_2;
    logic [CNT_W-1:0]  w_cnt_next_1, w_cnt_next_2;

    // Stall is decoded from the registered count, so a core stays held on a
    // full cycle even if a pair pops on that same edge.
    assign stall_1_o = w_full_1;
    assign stall_2_o = w_full_2;
    assign w_push_1  = retire_1_i && !stall_1_o;
    assign w_push_2  = retire_2_i && !stall_2_o;
    assign w_pop     = !w_empty_1 && !w_empty_2;

    retire_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo_1 (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (w_push_1),
        .wr_data (data_1_i),
        .pop     (w_pop),
        .head    (w_head_1),
        .full    (w_full_1),
        .empty   (w_empty_1),
        .count   (w_count_1)
    );

    retire_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo_2 (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (w_push_2),
        .wr_data (data_2_i),
        .pop     (w_pop),
        .head    (w_head_2),
        .full    (w_full_2),
        .empty   (w_empty_2),
        .count   (w_count_2)
    );

    // Skew is registered from the post-edge counts so that skew_o always
    // equals the current difference of the two FIFO occupancies.
    assign w_cnt_next_1 = w_count_1 + CNT_W'(w_push_1) - CNT_W'(w_pop);
    assign w_cnt_next_2 = w_count_2 + CNT_W'(w_push_2) - CNT_W'(w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retire_o <= 1'b0;
            data_1_o <= '0;
            data_2_o <= '0;
            skew_o   <= '0;
        end else begin
            retire_o <= w_pop;
            if (w_pop) begin
                data_1_o <= w_head_1;
                data_2_o <= w_head_2;
            end
            // Zero-extend both counts by one bit; the subtraction is then a
            // correct two's-complement result in -DEPTH..+DEPTH.
            skew_o <= {1'b0, w_cnt_next_1} - {1'b0, w_cnt_next_2};
        end
    end

`ifdef RETIRE_PAIR_CMP_EN
    // Set together with retire_o for the offending pair, then held until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mismatch_o <= 1'b0;
        end else if (w_pop && (w_head_1 != w_head_2)) begin
            mismatch_o <= 1'b1;
        end
    end
`else
    assign mismatch_o = 1'b0;
`endif

endmodule : retire_pair_buffer
`default_nettype wire

// File: tb/tb_retire_pair_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_retire_pair_buffer
// Purpose : Self-checking bench for retire_pair_buffer (DEPTH=4, DATA_W=32).
//           A queue-based model tracks what each core has had accepted and
//           which pair should appear on the outputs after every clock edge.
// Config  : honours RETIRE_PAIR_CMP_EN for the expected mismatch_o.
// Revision: 1.0 - initial release
// ============================================================================
module tb_retire_pair_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int SKEW_W = $clog2(DEPTH) + 2;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              retire_1_i = 1'b0;
    logic [DATA_W-1:0] data_1_i = '0;
    logic              retire_2_i = 1'b0;
    logic [DATA_W-1:0] data_2_i = '0;
    logic              stall_1_o, stall_2_o, retire_o, mismatch_o;
    logic [DATA_W-1:0] data_1_o, data_2_o;
    logic [SKEW_W-1:0] skew_o;

    retire_pair_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .retire_1_i (retire_1_i),
        .data_1_i   (data_1_i),
        .retire_2_i (retire_2_i),
        .data_2_i   (data_2_i),
        .stall_1_o  (stall_1_o),
        .stall_2_o  (stall_2_o),
        .retire_o   (retire_o),
        .data_1_o   (data_1_o),
        .data_2_o   (data_2_o),
        .skew_o     (skew_o),
        .mismatch_o (mismatch_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: records accepted but not yet paired, per core.
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] q2[$];
    logic              exp_retire = 1'b0;
    logic [DATA_W-1:0] exp_d1 = '0;
    logic [DATA_W-1:0] exp_d2 = '0;
    logic              exp_mis = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [63:0] skew_dut();
        logic signed [63:0] v;
        v = $signed(skew_o);
        return v;
    endfunction

    function automatic logic [63:0] skew_exp();
        longint v;
        v = longint'(q1.size()) - longint'(q2.size());
        return v;
    endfunction

    // One clock cycle: drive inputs, check stalls before the edge, advance
    // the model across the edge, then check registered outputs.
    task automatic step(input logic r1, input logic [DATA_W-1:0] d1,
                        input logic r2, input logic [DATA_W-1:0] d2,
                        input logic rs);
        logic acc1, acc2, pop;
        @(negedge clk);
        retire_1_i = r1; data_1_i = d1;
        retire_2_i = r2; data_2_i = d2;
        rst_i      = rs;
        chk("stall_1", stall_1_o, q1.size() == DEPTH);
        chk("stall_2", stall_2_o, q2.size() == DEPTH);
        acc1 = r1 && (q1.size() < DEPTH);
        acc2 = r2 && (q2.size() < DEPTH);
        pop  = (q1.size() > 0) && (q2.size() > 0);
        @(posedge clk);
        #1;
        if (rs) begin
            q1.delete(); q2.delete();
            exp_retire = 1'b0; exp_d1 = '0; exp_d2 = '0; exp_mis = 1'b0;
        end else begin
            exp_retire = pop;
            if (pop) begin
                exp_d1 = q1.pop_front();
                exp_d2 = q2.pop_front();
`ifdef RETIRE_PAIR_CMP_EN
                if (exp_d1 != exp_d2) exp_mis = 1'b1;
`endif
            end
            if (acc1) q1.push_back(d1);
            if (acc2) q2.push_back(d2);
        end
        chk("retire", retire_o, exp_retire);
        chk("data_1", data_1_o, exp_d1);
        chk("data_2", data_2_o, exp_d2);
        chk("skew", skew_dut(), skew_exp());
        chk("mismatch", mismatch_o, exp_mis);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_retire", retire_o, 0);
        chk("rst_skew", skew_dut(), 0);

        // 1: lockstep 0x10..0x13
        for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + i, 1'b1, 32'h10 + i, 1'b0);
        idle(3);
        chk("t1_skew", skew_dut(), 0);
        chk("t1_last_pair", data_1_o, 32'h13);

        // 2: core 1 fills while core 2 idle, then core 2 releases it
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + i, 1'b0, '0, 1'b0);
        chk("t2_skew_full", skew_dut(), 4);
        chk("t2_stall_1", stall_1_o, 1);
        step(1'b1, 32'h24, 1'b0, '0, 1'b0);          // held
        step(1'b1, 32'h24, 1'b1, 32'h20, 1'b0);      // held, core 2 accepted
        step(1'b1, 32'h24, 1'b0, '0, 1'b0);          // pair pops, still held
        chk("t2_pair", retire_o, 1);
        step(1'b1, 32'h24, 1'b0, '0, 1'b0);          // 5th accepted
        chk("t2_skew_refill", skew_dut(), 4);
        for (int i = 1; i < 5; i++) step(1'b0, '0, 1'b1, 32'h20 + i, 1'b0);
        idle(3);

        // 3: core 2 leads by 3
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 32'h30 + i, 1'b0);
        chk("t3_skew", skew_dut(), 64'hFFFF_FFFF_FFFF_FFFD);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + i, 1'b0, '0, 1'b0);
        idle(3);

        // 4: reset with records in flight
        do_reset();
        step(1'b1, 32'h40, 1'b0, '0, 1'b0);
        step(1'b1, 32'h41, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 32'h40, 1'b0);
        step(1'b1, 32'h42, 1'b1, 32'h41, 1'b1);      // reset, pop would occur
        chk("t4_retire", retire_o, 0);
        chk("t4_data_1", data_1_o, 0);
        idle(2);
        step(1'b1, 32'h44, 1'b1, 32'h44, 1'b0);
        idle(2);
        chk("t4_post_pair", data_2_o, 32'h44);

        // 5: unequal pair
        do_reset();
        step(1'b1, 32'hA, 1'b1, 32'hB, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0);
`ifdef RETIRE_PAIR_CMP_EN
        chk("t5_mis_set", mismatch_o, 1);
        idle(2);
        chk("t5_mis_sticky", mismatch_o, 1);
`else
        chk("t5_mis_off", mismatch_o, 0);
        idle(2);
        chk("t5_mis_off2", mismatch_o, 0);
`endif

        // 6: core 1 full while core 2 pushes
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h60 + i, 1'b0, '0, 1'b0);
        step(1'b1, 32'h64, 1'b1, 32'h60, 1'b0);
        step(1'b1, 32'h64, 1'b0, '0, 1'b0);
        step(1'b1, 32'h64, 1'b0, '0, 1'b0);
        for (int i = 1; i < 5; i++) step(1'b0, '0, 1'b1, 32'h60 + i, 1'b0);
        idle(3);

        // Randomized phases with differing retire rates and rare resets
        for (int ph = 0; ph < 4; ph++) begin
            int p1, p2;
            p1 = (ph == 1) ? 90 : (ph == 2) ? 20 : 60;
            p2 = (ph == 1) ? 20 : (ph == 2) ? 90 : 60;
            for (int i = 0; i < 200; i++) begin
                logic r1, r2, rs;
                logic [DATA_W-1:0] d1, d2;
                r1 = ($urandom_range(0, 99) < p1);
                r2 = ($urandom_range(0, 99) < p2);
                rs = ($urandom_range(0, 149) == 0);
                d1 = (ph == 3) ? $urandom() : $urandom_range(0, 3);
                d2 = (ph == 3) ? d1 : $urandom_range(0, 3);
                step(r1, d1, r2, d2, rs);
            end
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_retire_pair_buffer
`default_nettype wire
